// File: rtl/adc_serial_pkg.sv
// Shared constants, alignment FSM states and the sample bit-interleave decode
// for the 2-lane-per-channel ADC serial receiver.
package adc_serial_pkg;

  localparam int c_NB_CH    = 4;
  localparam int c_LANE_W   = 8;
  localparam int c_SAMPLE_W = 14;

  typedef enum logic [1:0] {
    SEARCH,
    SETTLE,
    VERIFY,
    LOCKED
  } align_state_t;

  // Odd lane carries the odd sample bits, even lane the even ones; bit 0 of
  // each lane word is a pad bit.
  function automatic logic signed [c_SAMPLE_W-1:0] f_decode_sample(
    input logic [c_LANE_W-1:0] o,
    input logic [c_LANE_W-1:0] e
  );
    return {o[7], e[7], o[6], e[6], o[5], e[5], o[4], e[4],
            o[3], e[3], o[2], e[2], o[1], e[1]};
  endfunction

endpackage

// File: rtl/adc_serial_frame_aligner_if.sv
// Lane-word inputs and decoded/status outputs of the frame aligner.
interface adc_serial_frame_aligner_if;
  import adc_serial_pkg::*;

  logic [c_LANE_W-1:0]          fr_word_i;
  logic [c_NB_CH*c_LANE_W-1:0]  dat_odd_i;
  logic [c_NB_CH*c_LANE_W-1:0]  dat_even_i;
  logic                         rescan_i;
  logic [c_NB_CH*16-1:0]        samples_o;
  logic                         samples_valid_o;
  logic                         synced_o;
  logic [2:0]                   bitslip_o;
  logic [7:0]                   loss_cnt_o;

  // SERDES/stimulus side
  modport master (
    output fr_word_i, dat_odd_i, dat_even_i, rescan_i,
    input  samples_o, samples_valid_o, synced_o, bitslip_o, loss_cnt_o
  );

  // Aligner side
  modport slave (
    input  fr_word_i, dat_odd_i, dat_even_i, rescan_i,
    output samples_o, samples_valid_o, synced_o, bitslip_o, loss_cnt_o
  );

endinterface

// File: rtl/adc_lane_bitslip.sv
// One lane of fabric bitslip: keeps the last two received words and picks the
// 8-bit window that starts k bits into the older word.
module adc_lane_bitslip
  import adc_serial_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [c_LANE_W-1:0] word_i,
  input  logic [2:0]          k_i,
  output logic [c_LANE_W-1:0] aligned_o
);

  logic [c_LANE_W-1:0]   w_cur_p0;
  logic [c_LANE_W-1:0]   w_prev_p1;
  logic [2*c_LANE_W-1:0] window;
  logic [3:0]            lsb;

  // Two-deep word history; cleared so a fresh search starts from known state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_cur_p0  <= '0;
      w_prev_p1 <= '0;
    end else begin
      w_cur_p0  <= word_i;
      w_prev_p1 <= w_cur_p0;
    end
  end

  // window[15-k : 8-k]
  assign window    = {w_prev_p1, w_cur_p0};
  assign lsb       = 4'd8 - {1'b0, k_i};
  assign aligned_o = window[lsb +: c_LANE_W];

endmodule

// File: rtl/adc_serial_frame_aligner.sv
// Frame aligner for the 4-channel, 2-lane-per-channel ADC serial stream.
// Searches the bit offset at which the frame lane shows the frame pattern,
// applies it to all data lanes and reassembles the 14-bit samples.
module adc_serial_frame_aligner
  import adc_serial_pkg::*;
#(
  parameter logic [7:0] g_FRAME_PATTERN = 8'hF0,
  parameter int         g_LOCK_CNT      = 16,
  parameter int         g_LOSS_CNT      = 4,
  parameter int         g_SETTLE        = 4
) (
  input logic                       clk_i,
  input logic                       rst_i,
  adc_serial_frame_aligner_if.slave bus
);

  localparam int LOCK_W   = $clog2(g_LOCK_CNT + 1);
  localparam int LOSS_W   = $clog2(g_LOSS_CNT + 1);
  localparam int SETTLE_W = $clog2(g_SETTLE + 1);

  align_state_t          state_q;
  logic [2:0]            k;
  logic [LOCK_W-1:0]     good_cnt;
  logic [LOSS_W-1:0]     bad_cnt;
  logic [SETTLE_W-1:0]   settle_cnt;
  logic                  synced_r;
  logic                  valid_r;
  logic [7:0]            loss_cnt_r;
  logic                  frame_ok;

  logic [c_LANE_W-1:0]   fr_aligned;
  logic [c_LANE_W-1:0]   odd_aligned  [c_NB_CH];
  logic [c_LANE_W-1:0]   even_aligned [c_NB_CH];
  logic [c_NB_CH*16-1:0] samples_p2;

  adc_lane_bitslip u_fr_lane (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .word_i    (bus.fr_word_i),
    .k_i       (k),
    .aligned_o (fr_aligned)
  );

  for (genvar c = 0; c < c_NB_CH; c++) begin : g_ch
    adc_lane_bitslip u_odd_lane (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .word_i    (bus.dat_odd_i[c*c_LANE_W +: c_LANE_W]),
      .k_i       (k),
      .aligned_o (odd_aligned[c])
    );
    adc_lane_bitslip u_even_lane (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .word_i    (bus.dat_even_i[c*c_LANE_W +: c_LANE_W]),
      .k_i       (k),
      .aligned_o (even_aligned[c])
    );
  end

  assign frame_ok = (fr_aligned == g_FRAME_PATTERN);

  // Decode stage: aligned lane pairs to left-justified 16-bit samples
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      samples_p2 <= '0;
    end else begin
      for (int c = 0; c < c_NB_CH; c++) begin
        samples_p2[16*c +: 16] <= {f_decode_sample(odd_aligned[c], even_aligned[c]), 2'b00};
      end
    end
  end

  // Alignment FSM; sync flags are decided from the same window as the samples
  // registered alongside, so valid needs no extra delay
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= SEARCH;
      k          <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      settle_cnt <= '0;
      synced_r   <= 1'b0;
      valid_r    <= 1'b0;
      loss_cnt_r <= '0;
    end else if (bus.rescan_i) begin
      state_q    <= SEARCH;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      settle_cnt <= '0;
      synced_r   <= 1'b0;
      valid_r    <= 1'b0;
    end else begin
      case (state_q)
        SEARCH: begin
          if (frame_ok) begin
            good_cnt <= LOCK_W'(1);
            state_q  <= VERIFY;
          end else begin
            k          <= k + 3'd1;
            settle_cnt <= '0;
            state_q    <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_W'(g_SETTLE - 1)) begin
            state_q <= SEARCH;
          end else begin
            settle_cnt <= settle_cnt + SETTLE_W'(1);
          end
        end
        VERIFY: begin
          if (!frame_ok) begin
            k          <= k + 3'd1;
            settle_cnt <= '0;
            state_q    <= SETTLE;
          end else if (good_cnt == LOCK_W'(g_LOCK_CNT - 1)) begin
            bad_cnt  <= '0;
            synced_r <= 1'b1;
            valid_r  <= 1'b1;
            state_q  <= LOCKED;
          end else begin
            good_cnt <= good_cnt + LOCK_W'(1);
          end
        end
        LOCKED: begin
          if (frame_ok) begin
            bad_cnt <= '0;
          end else if (bad_cnt == LOSS_W'(g_LOSS_CNT - 1)) begin
            bad_cnt  <= '0;
            synced_r <= 1'b0;
            valid_r  <= 1'b0;
            state_q  <= SEARCH;
            if (loss_cnt_r != 8'hFF) begin
              loss_cnt_r <= loss_cnt_r + 8'd1;
            end
          end else begin
            bad_cnt <= bad_cnt + LOSS_W'(1);
          end
        end
        default: state_q <= SEARCH;
      endcase
    end
  end

  assign bus.samples_o       = samples_p2;
  assign bus.samples_valid_o = valid_r;
  assign bus.synced_o        = synced_r;
  assign bus.bitslip_o       = k;
  assign bus.loss_cnt_o      = loss_cnt_r;

endmodule

// File: tb/tb_adc_serial_frame_aligner.sv
// Directed bench for adc_serial_frame_aligner: a serial transmitter model
// encodes triangular samples, delays every lane by a chosen bit count and
// checks lock behaviour and decoded samples.
module tb_adc_serial_frame_aligner;
  import adc_serial_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  always #5 clk_i = ~clk_i;

  adc_serial_frame_aligner_if aif ();

  adc_serial_frame_aligner dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (aif)
  );

  int checks   = 0;
  int failures = 0;

  int         dly     = 0;
  logic [7:0] fr_src  = 8'hF0;
  logic [7:0] fr_prev = 8'hF0;
  logic [7:0] odd_prev  [4];
  logic [7:0] even_prev [4];
  logic [13:0] hist [3][4];
  int tri_val = 360;
  int tri_dir = 8;

  function automatic logic [7:0] enc_odd(input logic [13:0] v);
    return {v[13], v[11], v[9], v[7], v[5], v[3], v[1], 1'b1};
  endfunction

  function automatic logic [7:0] enc_even(input logic [13:0] v);
    return {v[12], v[10], v[8], v[6], v[4], v[2], v[0], 1'b1};
  endfunction

  // Receive a continuous MSB-first bit stream that arrives d bits late
  function automatic logic [7:0] slip(input logic [7:0] prev, input logic [7:0] cur, input int d);
    logic [15:0] w;
    w = {prev, cur};
    w = w >> d;
    return w[7:0];
  endfunction

  function automatic logic [63:0] exp_samples();
    logic [63:0] s;
    for (int c = 0; c < 4; c++) s[16*c +: 16] = {hist[2][c], 2'b00};
    return s;
  endfunction

  task automatic cycle(input logic rescan = 1'b0);
    logic [13:0] v;
    logic [7:0]  o;
    logic [7:0]  e;
    @(negedge clk_i);
    for (int a = 2; a > 0; a--)
      for (int c = 0; c < 4; c++) hist[a][c] = hist[a-1][c];
    for (int c = 0; c < 4; c++) begin
      v = 14'(tri_val + 37 * c);
      hist[0][c] = v;
      o = enc_odd(v);
      e = enc_even(v);
      aif.dat_odd_i[8*c +: 8]  = slip(odd_prev[c], o, dly);
      aif.dat_even_i[8*c +: 8] = slip(even_prev[c], e, dly);
      odd_prev[c]  = o;
      even_prev[c] = e;
    end
    aif.fr_word_i = slip(fr_prev, fr_src, dly);
    fr_prev       = fr_src;
    aif.rescan_i  = rescan;
    if (tri_val + tri_dir > 400 || tri_val + tri_dir < -400) tri_dir = -tri_dir;
    tri_val += tri_dir;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    cycle();
    cycle();
    checks++; if (aif.synced_o !== 1'b0) begin failures++; $display("FAIL reset_synced got=%0b exp=0", aif.synced_o); end
    checks++; if (aif.samples_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", aif.samples_valid_o); end
    checks++; if (aif.bitslip_o !== 3'd0) begin failures++; $display("FAIL reset_bitslip got=%0d exp=0", aif.bitslip_o); end
    checks++; if (aif.loss_cnt_o !== 8'd0) begin failures++; $display("FAIL reset_loss got=%0d exp=0", aif.loss_cnt_o); end
    checks++; if (aif.samples_o !== 64'd0) begin failures++; $display("FAIL reset_samples got=%h exp=0", aif.samples_o); end
  endtask

  task automatic test_aligned_lock();
    int n = 0;
    dly   = 0;
    rst_i = 1'b0;
    while (aif.synced_o !== 1'b1 && n < 300) begin cycle(); n++; end
    checks++; if (aif.synced_o !== 1'b1) begin failures++; $display("FAIL aligned_lock got=%0b exp=1", aif.synced_o); end
    checks++; if (aif.bitslip_o !== 3'd0) begin failures++; $display("FAIL aligned_bitslip got=%0d exp=0", aif.bitslip_o); end
    checks++; if (aif.loss_cnt_o !== 8'd0) begin failures++; $display("FAIL aligned_loss got=%0d exp=0", aif.loss_cnt_o); end
    for (int i = 0; i < 60; i++) begin
      cycle();
      checks++;
      if (aif.samples_o !== exp_samples() || aif.samples_valid_o !== 1'b1) begin
        failures++;
        $display("FAIL aligned_samples[%0d] got=%h/%0b exp=%h/1", i, aif.samples_o, aif.samples_valid_o, exp_samples());
      end
    end
  endtask

  task automatic test_frame_loss();
    logic dropped = 1'b0;
    fr_src = 8'h00;
    for (int i = 0; i < 3; i++) cycle();
    fr_src = 8'hF0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (aif.synced_o !== 1'b1) dropped = 1'b1;
    end
    checks++; if (dropped !== 1'b0) begin failures++; $display("FAIL loss3_synced_dropped got=%0b exp=0", dropped); end
    checks++; if (aif.loss_cnt_o !== 8'd0) begin failures++; $display("FAIL loss3_count got=%0d exp=0", aif.loss_cnt_o); end
    fr_src = 8'h00;
    for (int i = 0; i < 4; i++) cycle();
    fr_src = 8'hF0;
    cycle();
    checks++; if (aif.synced_o !== 1'b1) begin failures++; $display("FAIL loss4_before got=%0b exp=1", aif.synced_o); end
    cycle();
    checks++; if (aif.synced_o !== 1'b0) begin failures++; $display("FAIL loss4_synced got=%0b exp=0", aif.synced_o); end
    checks++; if (aif.samples_valid_o !== 1'b0) begin failures++; $display("FAIL loss4_valid got=%0b exp=0", aif.samples_valid_o); end
    checks++; if (aif.loss_cnt_o !== 8'd1) begin failures++; $display("FAIL loss4_count got=%0d exp=1", aif.loss_cnt_o); end
    for (int i = 0; i < 15; i++) cycle();
    checks++; if (aif.synced_o !== 1'b0) begin failures++; $display("FAIL relock_early got=%0b exp=0", aif.synced_o); end
    cycle();
    checks++; if (aif.synced_o !== 1'b1) begin failures++; $display("FAIL relock got=%0b exp=1", aif.synced_o); end
    checks++; if (aif.bitslip_o !== 3'd0) begin failures++; $display("FAIL relock_bitslip got=%0d exp=0", aif.bitslip_o); end
  endtask

  task automatic test_rescan();
    cycle(1'b1);
    checks++; if (aif.synced_o !== 1'b0) begin failures++; $display("FAIL rescan_synced got=%0b exp=0", aif.synced_o); end
    checks++; if (aif.samples_valid_o !== 1'b0) begin failures++; $display("FAIL rescan_valid got=%0b exp=0", aif.samples_valid_o); end
    checks++; if (aif.loss_cnt_o !== 8'd1) begin failures++; $display("FAIL rescan_loss got=%0d exp=1", aif.loss_cnt_o); end
    checks++; if (aif.bitslip_o !== 3'd0) begin failures++; $display("FAIL rescan_bitslip got=%0d exp=0", aif.bitslip_o); end
    for (int i = 0; i < 15; i++) cycle();
    checks++; if (aif.synced_o !== 1'b0) begin failures++; $display("FAIL rescan_relock_early got=%0b exp=0", aif.synced_o); end
    cycle();
    checks++; if (aif.synced_o !== 1'b1 || aif.samples_valid_o !== 1'b1) begin failures++; $display("FAIL rescan_relock got=%0b/%0b exp=1/1", aif.synced_o, aif.samples_valid_o); end
  endtask

  task automatic test_delay3();
    int n = 0;
    dly   = 3;
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    checks++; if (aif.loss_cnt_o !== 8'd0) begin failures++; $display("FAIL delay3_reset_loss got=%0d exp=0", aif.loss_cnt_o); end
    while (aif.synced_o !== 1'b1 && n < 400) begin cycle(); n++; end
    checks++; if (aif.synced_o !== 1'b1) begin failures++; $display("FAIL delay3_lock got=%0b exp=1", aif.synced_o); end
    checks++; if (aif.bitslip_o !== 3'd3) begin failures++; $display("FAIL delay3_bitslip got=%0d exp=3", aif.bitslip_o); end
    for (int i = 0; i < 20; i++) begin
      cycle();
      checks++;
      if (aif.samples_o !== exp_samples() || aif.samples_valid_o !== 1'b1) begin
        failures++;
        $display("FAIL delay3_samples[%0d] got=%h/%0b exp=%h/1", i, aif.samples_o, aif.samples_valid_o, exp_samples());
      end
    end
  endtask

  task automatic test_reset_mid_verify();
    int n = 0;
    dly   = 5;
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    while (aif.bitslip_o !== 3'd5 && n < 100) begin cycle(); n++; end
    for (int i = 0; i < 6; i++) cycle();
    checks++; if (aif.bitslip_o !== 3'd5 || aif.synced_o !== 1'b0) begin failures++; $display("FAIL verify_state got=%0d/%0b exp=5/0", aif.bitslip_o, aif.synced_o); end
    rst_i = 1'b1;
    cycle(1'b1);
    rst_i = 1'b0;
    checks++; if (aif.bitslip_o !== 3'd0) begin failures++; $display("FAIL midreset_bitslip got=%0d exp=0", aif.bitslip_o); end
    checks++; if (aif.samples_o !== 64'd0) begin failures++; $display("FAIL midreset_samples got=%h exp=0", aif.samples_o); end
    checks++; if (aif.synced_o !== 1'b0 || aif.samples_valid_o !== 1'b0 || aif.loss_cnt_o !== 8'd0) begin failures++; $display("FAIL midreset_status got=%0b/%0b/%0d exp=0/0/0", aif.synced_o, aif.samples_valid_o, aif.loss_cnt_o); end
    cycle();
    checks++; if (aif.bitslip_o !== 3'd1) begin failures++; $display("FAIL midreset_search got=%0d exp=1", aif.bitslip_o); end
    n = 0;
    while (aif.synced_o !== 1'b1 && n < 200) begin cycle(); n++; end
    checks++; if (aif.synced_o !== 1'b1 || aif.bitslip_o !== 3'd5) begin failures++; $display("FAIL midreset_relock got=%0b/%0d exp=1/5", aif.synced_o, aif.bitslip_o); end
  endtask

  task automatic test_no_frame();
    logic [2:0] exp_k;
    logic       saw_sync = 1'b0;
    dly    = 0;
    fr_src = 8'h00;
    rst_i  = 1'b1;
    cycle();
    rst_i  = 1'b0;
    for (int i = 0; i < 45; i++) begin
      cycle();
      exp_k = 3'((i / 5) + 1);
      checks++;
      if (aif.bitslip_o !== exp_k) begin failures++; $display("FAIL noframe_bitslip[%0d] got=%0d exp=%0d", i, aif.bitslip_o, exp_k); end
      if (aif.synced_o !== 1'b0 || aif.samples_valid_o !== 1'b0) saw_sync = 1'b1;
    end
    checks++; if (saw_sync !== 1'b0) begin failures++; $display("FAIL noframe_synced got=%0b exp=0", saw_sync); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    aif.fr_word_i  = 8'h00;
    aif.dat_odd_i  = '0;
    aif.dat_even_i = '0;
    aif.rescan_i   = 1'b0;
    for (int c = 0; c < 4; c++) begin
      odd_prev[c]  = 8'h00;
      even_prev[c] = 8'h00;
      for (int a = 0; a < 3; a++) hist[a][c] = '0;
    end
    test_reset();
    test_aligned_lock();
    test_frame_loss();
    test_rescan();
    test_delay3();
    test_reset_mid_verify();
    test_no_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
